// File: rtl/prog_loader.sv
// Program image loader: accepts a header / payload / checksum word stream from the
// UART, writes the payload into instruction RAM and holds the CPU in reset until verified.
module prog_loader #(
    parameter logic [15:0] MAGIC     = 16'hB007,
    parameter int          MAX_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        prog_mode,
    input  logic        in_WE,
    input  logic [31:0] in_WD,
    output logic        mem_WE,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] word_count,
    output logic        cpu_reset_hold
);

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        prog_q;
    logic        prog_rise;
    logic        prog_fall;
    logic        in_frame;
    logic [15:0] hdr_len;
    logic [15:0] frame_len;
    logic [31:0] checksum;
    logic        take_header;
    logic        take_word;
    logic        enter_done;
    logic        enter_error;
    logic [1:0]  error_code_next;

    assign prog_rise = prog_mode & ~prog_q;
    assign prog_fall = ~prog_mode & prog_q;
    assign in_frame  = (state == HEADER) || (state == PAYLOAD) || (state == CHECK);
    assign hdr_len   = in_WD[15:0];

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            prog_q <= 1'b0;
        end else begin
            state  <= state_next;
            prog_q <= prog_mode;
        end
    end

    // A restart or abort takes priority over any word strobed in the same cycle.
    always_comb begin
        state_next      = state;
        take_header     = 1'b0;
        take_word       = 1'b0;
        enter_done      = 1'b0;
        enter_error     = 1'b0;
        error_code_next = err_code;

        if (prog_rise) begin
            state_next = HEADER;
        end else if (prog_fall && in_frame) begin
            state_next      = ERROR;
            enter_error     = 1'b1;
            error_code_next = 2'd0;
        end else if (in_WE) begin
            case (state)
                HEADER: begin
                    if (in_WD[31:16] != MAGIC) begin
                        state_next      = ERROR;
                        enter_error     = 1'b1;
                        error_code_next = 2'd1;
                    end else if ((hdr_len == 16'd0) || ({1'b0, hdr_len} > MAX_LEN)) begin
                        state_next      = ERROR;
                        enter_error     = 1'b1;
                        error_code_next = 2'd2;
                    end else begin
                        take_header = 1'b1;
                        state_next  = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    take_word = 1'b1;
                    if ((word_count + 16'd1) == frame_len) begin
                        state_next = CHECK;
                    end
                end
                CHECK: begin
                    if (in_WD == checksum) begin
                        enter_done = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next      = ERROR;
                        enter_error     = 1'b1;
                        error_code_next = 2'd3;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // word_count doubles as the payload index, since it is cleared on every restart.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            mem_WE         <= 1'b0;
            mem_A          <= 32'd0;
            mem_WD         <= 32'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            err_code       <= 2'd0;
            word_count     <= 16'd0;
            cpu_reset_hold <= 1'b0;
            frame_len      <= 16'd0;
            checksum       <= 32'd0;
        end else begin
            mem_WE <= 1'b0;

            if (prog_rise) begin
                word_count     <= 16'd0;
                checksum       <= 32'd0;
                done           <= 1'b0;
                err            <= 1'b0;
                err_code       <= 2'd0;
                busy           <= 1'b1;
                cpu_reset_hold <= 1'b1;
            end

            if (take_header) begin
                frame_len <= hdr_len;
            end

            if (take_word) begin
                mem_WE     <= 1'b1;
                mem_A      <= BASE_ADDR + {14'd0, word_count, 2'b00};
                mem_WD     <= in_WD;
                checksum   <= checksum + in_WD;
                word_count <= word_count + 16'd1;
            end

            if (enter_done) begin
                done           <= 1'b1;
                busy           <= 1'b0;
                cpu_reset_hold <= 1'b0;
            end

            if (enter_error) begin
                err            <= 1'b1;
                err_code       <= error_code_next;
                busy           <= 1'b0;
                cpu_reset_hold <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of frames, hand-written corner sequences,
// and randomized frames checked against a frame-level reference model.
module tb_prog_loader;

    logic        CLK = 1'b0;
    logic        reset;
    logic        prog_mode;
    logic        in_WE;
    logic [31:0] in_WD;
    logic        mem_WE;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] word_count;
    logic        cpu_reset_hold;

    prog_loader dut (
        .CLK            (CLK),
        .reset          (reset),
        .prog_mode      (prog_mode),
        .in_WE          (in_WE),
        .in_WD          (in_WD),
        .mem_WE         (mem_WE),
        .mem_A          (mem_A),
        .mem_WD         (mem_WD),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .err_code       (err_code),
        .word_count     (word_count),
        .cpu_reset_hold (cpu_reset_hold)
    );

    always #5 CLK = ~CLK;

    int nChecks = 0;
    int nFails  = 0;
    int cycleCount = 0;

    logic [31:0] gotAddr[$];
    logic [31:0] gotData[$];
    int          gotCycle[$];
    logic [31:0] expAddr[$];
    logic [31:0] expData[$];
    logic [31:0] payBuf[0:1023];

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [31:0] p2;
        int          npay;
        logic [31:0] csum;
        logic        expDone;
        logic        expErr;
        logic [1:0]  expCode;
        int          expWc;
    } vec_t;

    vec_t vecs[6];

    always @(posedge CLK) cycleCount <= cycleCount + 1;

    // Every cycle with mem_WE high is one write into instruction RAM.
    always @(negedge CLK) begin
        if (mem_WE === 1'b1) begin
            gotAddr.push_back(mem_A);
            gotData.push_back(mem_WD);
            gotCycle.push_back(cycleCount);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge CLK);
            #1;
        end
    endtask

    task automatic sendWord(input logic [31:0] w);
        in_WE = 1'b1;
        in_WD = w;
        tick(1);
        in_WE = 1'b0;
    endtask

    task automatic restartLoad();
        prog_mode = 1'b0;
        tick(1);
        prog_mode = 1'b1;
        tick(1);
    endtask

    task automatic checkStatus(input string name, input logic d, input logic e, input logic [1:0] code,
                               input int wc, input logic hold, input logic bsy);
        checkOutput({name, "_done"}, 32'(done), 32'(d));
        checkOutput({name, "_err"}, 32'(err), 32'(e));
        checkOutput({name, "_err_code"}, 32'(err_code), 32'(code));
        checkOutput({name, "_word_count"}, 32'(word_count), 32'(wc));
        checkOutput({name, "_cpu_reset_hold"}, 32'(cpu_reset_hold), 32'(hold));
        checkOutput({name, "_busy"}, 32'(busy), 32'(bsy));
    endtask

    task automatic checkWrites(input string name);
        int n;
        checkOutput({name, "_wr_count"}, 32'(gotAddr.size()), 32'(expAddr.size()));
        n = (gotAddr.size() < expAddr.size()) ? gotAddr.size() : expAddr.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_wr%0d_addr", name, i), gotAddr[i], expAddr[i]);
            checkOutput($sformatf("%s_wr%0d_data", name, i), gotData[i], expData[i]);
        end
        gotAddr.delete();
        gotData.delete();
        gotCycle.delete();
        expAddr.delete();
        expData.delete();
    endtask

    // Frame-level model: what a whole header/payload/checksum frame should leave behind.
    task automatic modelFrame(input logic [31:0] hdr, input logic [31:0] csum,
                              output logic eDone, output logic eErr, output logic [1:0] eCode, output int eWc);
        int          len;
        logic [31:0] sum;
        eDone = 1'b0;
        eErr  = 1'b1;
        eCode = 2'd0;
        eWc   = 0;
        len   = int'(hdr[15:0]);
        if (hdr[31:16] != 16'hB007) begin
            eCode = 2'd1;
        end else if (len == 0 || len > 1024) begin
            eCode = 2'd2;
        end else begin
            sum = 32'd0;
            for (int i = 0; i < len; i++) begin
                sum = sum + payBuf[i];
                expAddr.push_back(32'(4 * i));
                expData.push_back(payBuf[i]);
            end
            eWc = len;
            if (csum == sum) begin
                eDone = 1'b1;
                eErr  = 1'b0;
            end else begin
                eCode = 2'd3;
            end
        end
    endtask

    task automatic applyStimulus(input logic [31:0] hdr, input int npay, input logic [31:0] csum, input int gapMax);
        restartLoad();
        sendWord(hdr);
        for (int i = 0; i < npay; i++) begin
            if (gapMax > 0) tick(int'($urandom_range(0, gapMax)));
            sendWord(payBuf[i]);
        end
        if (gapMax > 0) tick(int'($urandom_range(0, gapMax)));
        sendWord(csum);
        tick(2);
    endtask

    function automatic vec_t mkVec(input logic [31:0] hdr, input logic [31:0] p0, input logic [31:0] p1,
                                   input logic [31:0] p2, input int npay, input logic [31:0] csum,
                                   input logic d, input logic e, input logic [1:0] code, input int wc);
        vec_t v;
        v.hdr = hdr; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.npay = npay; v.csum = csum;
        v.expDone = d; v.expErr = e; v.expCode = code; v.expWc = wc;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        eDone;
        logic        eErr;
        logic [1:0]  eCode;
        int          eWc;
        int          kind;
        int          len;
        int          npay;
        logic [31:0] hdr;
        logic [31:0] csum;
        logic [31:0] sum;

        vecs[0] = mkVec(32'hB0070003, 32'h1, 32'h2, 32'h3, 3, 32'h6, 1'b1, 1'b0, 2'd0, 3);
        vecs[1] = mkVec(32'h12340003, 32'h1, 32'h2, 32'h3, 3, 32'h6, 1'b0, 1'b1, 2'd1, 0);
        vecs[2] = mkVec(32'hB0070000, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b0, 1'b1, 2'd2, 0);
        vecs[3] = mkVec(32'hB0070401, 32'h5, 32'h6, 32'h0, 2, 32'hB, 1'b0, 1'b1, 2'd2, 0);
        vecs[4] = mkVec(32'hB0070002, 32'hFFFFFFFF, 32'h2, 32'h0, 2, 32'h1, 1'b1, 1'b0, 2'd0, 2);
        vecs[5] = mkVec(32'hB0070002, 32'hFFFFFFFF, 32'h2, 32'h0, 2, 32'h3, 1'b0, 1'b1, 2'd3, 2);

        reset     = 1'b1;
        prog_mode = 1'b0;
        in_WE     = 1'b0;
        in_WD     = 32'd0;
        tick(2);
        reset = 1'b0;
        tick(1);
        checkStatus("reset", 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b0);
        checkOutput("reset_mem_WE", 32'(mem_WE), 32'd0);
        checkOutput("reset_mem_A", mem_A, 32'd0);
        checkOutput("reset_mem_WD", mem_WD, 32'd0);

        for (int k = 0; k < 6; k++) begin
            payBuf[0] = vecs[k].p0;
            payBuf[1] = vecs[k].p1;
            payBuf[2] = vecs[k].p2;
            for (int i = 0; i < vecs[k].expWc; i++) begin
                expAddr.push_back(32'(4 * i));
                expData.push_back(payBuf[i]);
            end
            applyStimulus(vecs[k].hdr, vecs[k].npay, vecs[k].csum, 1);
            checkStatus($sformatf("vec%0d", k), vecs[k].expDone, vecs[k].expErr, vecs[k].expCode,
                        vecs[k].expWc, vecs[k].expErr, 1'b0);
            checkWrites($sformatf("vec%0d", k));
        end

        // Exact write timing, then abort mid-payload and restart with a full frame.
        restartLoad();
        checkStatus("abort_start", 1'b0, 1'b0, 2'd0, 0, 1'b1, 1'b1);
        sendWord(32'hB0070003);
        in_WE = 1'b1;
        in_WD = 32'hA5A50001;
        @(negedge CLK);
        checkOutput("abort_wr_not_early", 32'(mem_WE), 32'd0);
        @(posedge CLK);
        #1;
        in_WE = 1'b0;
        @(negedge CLK);
        checkOutput("abort_wr_pulse", 32'(mem_WE), 32'd1);
        checkOutput("abort_wr_addr", mem_A, 32'd0);
        checkOutput("abort_wr_data", mem_WD, 32'hA5A50001);
        @(negedge CLK);
        checkOutput("abort_wr_single", 32'(mem_WE), 32'd0);
        checkOutput("abort_addr_held", mem_A, 32'd0);
        checkOutput("abort_data_held", mem_WD, 32'hA5A50001);
        @(posedge CLK);
        #1;
        prog_mode = 1'b0;
        tick(2);
        checkStatus("abort", 1'b0, 1'b1, 2'd0, 1, 1'b1, 1'b0);
        expAddr.push_back(32'd0);
        expData.push_back(32'hA5A50001);
        checkWrites("abort");
        prog_mode = 1'b1;
        tick(1);
        checkStatus("restart", 1'b0, 1'b0, 2'd0, 0, 1'b1, 1'b1);
        sendWord(32'hB0070003);
        sendWord(32'h7);
        sendWord(32'h8);
        sendWord(32'h9);
        sendWord(32'h18);
        tick(2);
        checkStatus("restart_end", 1'b1, 1'b0, 2'd0, 3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expAddr.push_back(32'(4 * i));
            expData.push_back(32'(7 + i));
        end
        checkWrites("restart");

        // Back-to-back words must yield consecutive single-cycle writes.
        restartLoad();
        sendWord(32'hB0070004);
        sendWord(32'd10);
        sendWord(32'd20);
        sendWord(32'd30);
        sendWord(32'd40);
        sendWord(32'd100);
        tick(2);
        checkStatus("b2b", 1'b1, 1'b0, 2'd0, 4, 1'b0, 1'b0);
        if (gotCycle.size() == 4) begin
            for (int i = 1; i < 4; i++)
                checkOutput($sformatf("b2b_consecutive%0d", i), 32'(gotCycle[i]), 32'(gotCycle[0] + i));
        end
        for (int i = 0; i < 4; i++) begin
            expAddr.push_back(32'(4 * i));
            expData.push_back(32'(10 * (i + 1)));
        end
        checkWrites("b2b");

        // Abort coinciding with a word: the word is dropped.
        restartLoad();
        sendWord(32'hB0070002);
        prog_mode = 1'b0;
        in_WE     = 1'b1;
        in_WD     = 32'h55;
        tick(1);
        in_WE = 1'b0;
        tick(2);
        checkStatus("fall_we", 1'b0, 1'b1, 2'd0, 0, 1'b1, 1'b0);
        checkWrites("fall_we");

        // Restart coinciding with a word: the word is not taken as a header.
        prog_mode = 1'b1;
        in_WE     = 1'b1;
        in_WD     = 32'hB0070001;
        tick(1);
        in_WE = 1'b0;
        sendWord(32'hB0070001);
        sendWord(32'h77);
        sendWord(32'h77);
        tick(2);
        checkStatus("rise_we", 1'b1, 1'b0, 2'd0, 1, 1'b0, 1'b0);
        expAddr.push_back(32'd0);
        expData.push_back(32'h77);
        checkWrites("rise_we");

        // Reset during the second payload word.
        restartLoad();
        sendWord(32'hB0070004);
        sendWord(32'hAA);
        tick(2);
        reset     = 1'b1;
        prog_mode = 1'b0;
        in_WE     = 1'b1;
        in_WD     = 32'hBB;
        #1;
        checkStatus("rst_mid", 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b0);
        checkOutput("rst_mid_mem_WE", 32'(mem_WE), 32'd0);
        checkOutput("rst_mid_mem_A", mem_A, 32'd0);
        checkOutput("rst_mid_mem_WD", mem_WD, 32'd0);
        tick(1);
        in_WE = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(1);
        sendWord(32'hCC);
        sendWord(32'hB0070001);
        sendWord(32'hDD);
        tick(2);
        checkStatus("rst_after", 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b0);
        expAddr.push_back(32'd0);
        expData.push_back(32'hAA);
        checkWrites("rst_after");

        // Randomized frames against the model.
        for (int f = 0; f < 20; f++) begin
            kind = int'($urandom_range(0, 9));
            for (int i = 0; i < 16; i++) payBuf[i] = $urandom;
            if (kind == 0) begin
                hdr = $urandom;
                if (hdr[31:16] == 16'hB007) hdr[31] = ~hdr[31];
                npay = int'($urandom_range(0, 3));
                csum = $urandom;
            end else if (kind == 1) begin
                len  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1025, 65535));
                hdr  = {16'hB007, 16'(len)};
                npay = int'($urandom_range(0, 3));
                csum = $urandom;
            end else begin
                len  = int'($urandom_range(1, 12));
                hdr  = {16'hB007, 16'(len)};
                npay = len;
                sum  = 32'd0;
                for (int i = 0; i < len; i++) sum = sum + payBuf[i];
                csum = ($urandom_range(0, 3) == 0) ? sum + 32'($urandom_range(1, 1000)) : sum;
            end
            modelFrame(hdr, csum, eDone, eErr, eCode, eWc);
            applyStimulus(hdr, npay, csum, 2);
            checkStatus($sformatf("rand%0d", f), eDone, eErr, eCode, eWc, eErr, 1'b0);
            checkWrites($sformatf("rand%0d", f));
        end

        // Largest accepted frame.
        sum = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            payBuf[i] = $urandom;
            sum = sum + payBuf[i];
        end
        modelFrame(32'hB0070400, sum, eDone, eErr, eCode, eWc);
        applyStimulus(32'hB0070400, 1024, sum, 0);
        checkStatus("max_len", eDone, eErr, eCode, eWc, eErr, 1'b0);
        checkWrites("max_len");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
